// File: rtl/iq_fir_sequencer.sv
// iq_fir_sequencer: splits interleaved I/Q words into the FIR input FIFO pair in lockstep,
// re-interleaves the FIR result pair into one output FIFO, and counts output frames.
module iq_fir_sequencer #(
  parameter int DATA_SIZE = 32,
  parameter int FRAME_LEN = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] iq_in_dout,
  input  logic                 iq_in_empty,
  output logic                 iq_in_rd_en,
  output logic [DATA_SIZE-1:0] xreal_out_din,
  output logic [DATA_SIZE-1:0] ximag_out_din,
  output logic                 xreal_out_wr_en,
  output logic                 ximag_out_wr_en,
  input  logic                 xreal_out_full,
  input  logic                 ximag_out_full,
  input  logic [DATA_SIZE-1:0] yreal_in_dout,
  input  logic [DATA_SIZE-1:0] yimag_in_dout,
  input  logic                 yreal_in_empty,
  input  logic                 yimag_in_empty,
  output logic                 yreal_in_rd_en,
  output logic                 yimag_in_rd_en,
  output logic [DATA_SIZE-1:0] iq_out_din,
  output logic                 iq_out_wr_en,
  input  logic                 iq_out_full,
  output logic                 frame_done,
  output logic [15:0]          frame_count
);
  localparam int CW = $clog2(FRAME_LEN + 1);
  typedef enum logic {IN_RE, IN_IM} in_state_e;
  typedef enum logic {OUT_RE, OUT_IM} out_state_e;
  in_state_e            in_q, in_d;
  out_state_e           out_q, out_d;
  logic [DATA_SIZE-1:0] re_hold_q, re_hold_d, im_hold_q, im_hold_d;
  logic [CW-1:0]        pair_cnt_q, pair_cnt_d;
  logic [15:0]          frame_count_q, frame_count_d;
  logic                 frame_done_q, frame_done_d;
  logic                 in_re_go, in_im_go, out_re_go, out_im_go, frame_end;
  // every strobe is gated by reset so nothing moves while the FIFOs are being flushed
  always_comb begin
    in_re_go      = !reset && in_q == IN_RE && !iq_in_empty;
    in_im_go      = !reset && in_q == IN_IM && !iq_in_empty && !xreal_out_full && !ximag_out_full;
    out_re_go     = !reset && out_q == OUT_RE && !yreal_in_empty && !yimag_in_empty && !iq_out_full;
    out_im_go     = !reset && out_q == OUT_IM && !iq_out_full;
    frame_end     = out_im_go && pair_cnt_q == CW'(FRAME_LEN - 1);
    in_d          = in_re_go ? IN_IM : in_im_go ? IN_RE : in_q;
    out_d         = out_re_go ? OUT_IM : out_im_go ? OUT_RE : out_q;
    re_hold_d     = in_re_go ? iq_in_dout : re_hold_q;
    im_hold_d     = out_re_go ? yimag_in_dout : im_hold_q;
    pair_cnt_d    = frame_end ? '0 : out_im_go ? pair_cnt_q + 1'b1 : pair_cnt_q;
    frame_done_d  = frame_end;
    frame_count_d = frame_count_q + {15'd0, frame_end};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      in_q          <= IN_RE;
      out_q         <= OUT_RE;
      re_hold_q     <= '0;
      im_hold_q     <= '0;
      pair_cnt_q    <= '0;
      frame_count_q <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      in_q          <= in_d;
      out_q         <= out_d;
      re_hold_q     <= re_hold_d;
      im_hold_q     <= im_hold_d;
      pair_cnt_q    <= pair_cnt_d;
      frame_count_q <= frame_count_d;
      frame_done_q  <= frame_done_d;
    end
  end
  assign iq_in_rd_en     = in_re_go | in_im_go;
  assign xreal_out_wr_en = in_im_go;
  assign ximag_out_wr_en = in_im_go;
  assign xreal_out_din   = in_im_go ? re_hold_q : '0;
  assign ximag_out_din   = in_im_go ? iq_in_dout : '0;
  assign yreal_in_rd_en  = out_re_go;
  assign yimag_in_rd_en  = out_re_go;
  assign iq_out_wr_en    = out_re_go | out_im_go;
  assign iq_out_din      = out_re_go ? yreal_in_dout : out_im_go ? im_hold_q : '0;
  assign frame_done      = frame_done_q;
  assign frame_count     = frame_count_q;
endmodule

// File: tb/tb_iq_fir_sequencer.sv
// tb_iq_fir_sequencer: directed vector table plus queue-based FIFO/stream model with random stalls.
module tb_iq_fir_sequencer;
  localparam int FL = 4;
  logic        clock, reset;
  logic [31:0] iq_in_dout, xreal_out_din, ximag_out_din, yreal_in_dout, yimag_in_dout, iq_out_din;
  logic        iq_in_empty, iq_in_rd_en, xreal_out_wr_en, ximag_out_wr_en, xreal_out_full, ximag_out_full;
  logic        yreal_in_empty, yimag_in_empty, yreal_in_rd_en, yimag_in_rd_en, iq_out_wr_en, iq_out_full;
  logic        frame_done;
  logic [15:0] frame_count;

  iq_fir_sequencer #(.DATA_SIZE(32), .FRAME_LEN(FL)) dut (
    .clock(clock), .reset(reset),
    .iq_in_dout(iq_in_dout), .iq_in_empty(iq_in_empty), .iq_in_rd_en(iq_in_rd_en),
    .xreal_out_din(xreal_out_din), .ximag_out_din(ximag_out_din),
    .xreal_out_wr_en(xreal_out_wr_en), .ximag_out_wr_en(ximag_out_wr_en),
    .xreal_out_full(xreal_out_full), .ximag_out_full(ximag_out_full),
    .yreal_in_dout(yreal_in_dout), .yimag_in_dout(yimag_in_dout),
    .yreal_in_empty(yreal_in_empty), .yimag_in_empty(yimag_in_empty),
    .yreal_in_rd_en(yreal_in_rd_en), .yimag_in_rd_en(yimag_in_rd_en),
    .iq_out_din(iq_out_din), .iq_out_wr_en(iq_out_wr_en), .iq_out_full(iq_out_full),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // fi = {rst, iq_in_empty, xreal_full, ximag_full, yreal_empty, yimag_empty, iq_out_full}
  // fe = {iq_in_rd_en, x_wr_en, y_rd_en, iq_out_wr_en, frame_done}
  typedef struct packed {
    logic [6:0]  fi;
    logic [31:0] din, yr, yi;
    logic [4:0]  fe;
    logic [31:0] xr, xi, od;
  } vec_t;
  vec_t tbl [34];

  int errors = 0, checks = 0, nwords = 0, fd_seen = 0;
  logic        fd_exp = 1'b0;
  logic [15:0] fc_exp = 16'd0;
  logic [31:0] inq[$], yrq[$], yiq[$], exp_out[$];
  logic [63:0] exp_x[$];

  task automatic chk1(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin errors++; $display("FAIL %s: got %b expected %b", n, a, e); end
  endtask
  task automatic chk16(input string n, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin errors++; $display("FAIL %s: got %0d expected %0d", n, a, e); end
  endtask
  task automatic chk32(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin errors++; $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e); end
  endtask

  task automatic push_in(input logic [31:0] r, input logic [31:0] i);
    inq.push_back(r); inq.push_back(i); exp_x.push_back({r, i});
  endtask
  task automatic push_res(input logic [31:0] r, input logic [31:0] i);
    yrq.push_back(r); yiq.push_back(i); exp_out.push_back(r); exp_out.push_back(i);
  endtask

  // one clock of the FIFO-level model: present queue heads, then score what the DUT did
  task automatic cyc(input bit rnd);
    logic [63:0] ex;
    @(negedge clock);
    reset          = 1'b0;
    iq_in_empty    = inq.size() == 0 || (rnd && $urandom_range(3) == 0);
    iq_in_dout     = inq.size() != 0 ? inq[0] : $urandom;
    xreal_out_full = rnd && $urandom_range(4) == 0;
    ximag_out_full = rnd && $urandom_range(4) == 0;
    yreal_in_empty = yrq.size() == 0 || (rnd && $urandom_range(3) == 0);
    yimag_in_empty = yiq.size() == 0 || (rnd && $urandom_range(3) == 0);
    yreal_in_dout  = yrq.size() != 0 ? yrq[0] : $urandom;
    yimag_in_dout  = yiq.size() != 0 ? yiq[0] : $urandom;
    iq_out_full    = rnd && $urandom_range(3) == 0;
    #1;
    chk1("frame_done", frame_done, fd_exp);
    chk16("frame_count", frame_count, fc_exp);
    if (frame_done) fd_seen++;
    fd_exp = 1'b0;
    chk1("x_wr_lockstep", ximag_out_wr_en, xreal_out_wr_en);
    chk1("y_rd_lockstep", yimag_in_rd_en, yreal_in_rd_en);
    if (iq_in_rd_en) begin
      chk1("in_pop_when_empty", iq_in_empty, 1'b0);
      if (inq.size() != 0) void'(inq.pop_front());
    end
    if (xreal_out_wr_en) begin
      chk1("x_wr_when_full", xreal_out_full | ximag_out_full, 1'b0);
      if (exp_x.size() == 0) begin
        checks++; errors++;
        $display("FAIL x_extra_write: got 0x%0h/0x%0h expected no write", xreal_out_din, ximag_out_din);
      end else begin
        ex = exp_x.pop_front();
        chk32("xreal_din", xreal_out_din, ex[63:32]);
        chk32("ximag_din", ximag_out_din, ex[31:0]);
      end
    end else begin
      chk32("xreal_din_idle", xreal_out_din, 32'h0);
      chk32("ximag_din_idle", ximag_out_din, 32'h0);
    end
    if (yreal_in_rd_en) begin
      chk1("y_pop_when_empty", yreal_in_empty | yimag_in_empty, 1'b0);
      if (yrq.size() != 0) void'(yrq.pop_front());
      if (yiq.size() != 0) void'(yiq.pop_front());
    end
    if (iq_out_wr_en) begin
      chk1("out_wr_when_full", iq_out_full, 1'b0);
      if (exp_out.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_extra_write: got 0x%0h expected no write", iq_out_din);
      end else chk32("iq_out_din", iq_out_din, exp_out.pop_front());
      nwords++;
      if (nwords % (2 * FL) == 0) begin fd_exp = 1'b1; fc_exp++; end
    end else chk32("iq_out_din_idle", iq_out_din, 32'h0);
  endtask

  task automatic do_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      reset = 1'b1; iq_in_empty = 1'b0; iq_in_dout = $urandom;
      xreal_out_full = 1'b0; ximag_out_full = 1'b0;
      yreal_in_empty = 1'b0; yimag_in_empty = 1'b0;
      yreal_in_dout = $urandom; yimag_in_dout = $urandom; iq_out_full = 1'b0;
      #1;
      chk1("rst_in_rd", iq_in_rd_en, 1'b0);
      chk1("rst_xr_wr", xreal_out_wr_en, 1'b0);
      chk1("rst_xi_wr", ximag_out_wr_en, 1'b0);
      chk32("rst_xr_din", xreal_out_din, 32'h0);
      chk32("rst_xi_din", ximag_out_din, 32'h0);
      chk1("rst_yr_rd", yreal_in_rd_en, 1'b0);
      chk1("rst_yi_rd", yimag_in_rd_en, 1'b0);
      chk1("rst_out_wr", iq_out_wr_en, 1'b0);
      chk32("rst_out_din", iq_out_din, 32'h0);
      if (c == 1) begin
        chk1("rst_frame_done", frame_done, 1'b0);
        chk16("rst_frame_count", frame_count, 16'd0);
      end
    end
    inq.delete(); yrq.delete(); yiq.delete(); exp_out.delete(); exp_x.delete();
    nwords = 0; fd_exp = 1'b0; fc_exp = 16'd0;
  endtask

  task automatic drain(input bit rnd, input int budget);
    int n = 0;
    while ((inq.size() != 0 || yrq.size() != 0 || exp_x.size() != 0 || exp_out.size() != 0) && n < budget) begin
      cyc(rnd);
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d cycles required fewer than %0d", n, budget);
    end
    cyc(1'b0);
    cyc(1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; iq_in_dout = '0; iq_in_empty = 1'b1; xreal_out_full = 1'b0; ximag_out_full = 1'b0;
    yreal_in_dout = '0; yimag_in_dout = '0; yreal_in_empty = 1'b1; yimag_in_empty = 1'b1; iq_out_full = 1'b0;
    tbl[0]  = '{7'b1000000, 32'h55, 32'h1,  32'h2,  5'b00000, 32'h0,  32'h0,  32'h0};
    tbl[1]  = '{7'b1000000, 32'h55, 32'h1,  32'h2,  5'b00000, 32'h0,  32'h0,  32'h0};
    tbl[2]  = '{7'b0000110, 32'h10, 32'h0,  32'h0,  5'b10000, 32'h0,  32'h0,  32'h0};
    tbl[3]  = '{7'b0000110, 32'h20, 32'h0,  32'h0,  5'b11000, 32'h10, 32'h20, 32'h0};
    tbl[4]  = '{7'b0000110, 32'h30, 32'h0,  32'h0,  5'b10000, 32'h0,  32'h0,  32'h0};
    for (int r = 5; r < 10; r++) tbl[r] = '{7'b0100110, 32'h99, 32'h0, 32'h0, 5'b00000, 32'h0, 32'h0, 32'h0};
    tbl[10] = '{7'b0000110, 32'h40, 32'h0,  32'h0,  5'b11000, 32'h30, 32'h40, 32'h0};
    tbl[11] = '{7'b0000110, 32'h50, 32'h0,  32'h0,  5'b10000, 32'h0,  32'h0,  32'h0};
    for (int r = 12; r < 15; r++) tbl[r] = '{7'b0001110, 32'h60, 32'h0, 32'h0, 5'b00000, 32'h0, 32'h0, 32'h0};
    tbl[15] = '{7'b0000110, 32'h60, 32'h0,  32'h0,  5'b11000, 32'h50, 32'h60, 32'h0};
    tbl[16] = '{7'b0000110, 32'h70, 32'h0,  32'h0,  5'b10000, 32'h0,  32'h0,  32'h0};
    tbl[17] = '{7'b0010110, 32'h80, 32'h0,  32'h0,  5'b00000, 32'h0,  32'h0,  32'h0};
    tbl[18] = '{7'b0000110, 32'h80, 32'h0,  32'h0,  5'b11000, 32'h70, 32'h80, 32'h0};
    tbl[19] = '{7'b0100000, 32'h0,  32'hA,  32'hB,  5'b00110, 32'h0,  32'h0,  32'hA};
    tbl[20] = '{7'b0100000, 32'h0,  32'hC,  32'hD,  5'b00010, 32'h0,  32'h0,  32'hB};
    tbl[21] = '{7'b0100000, 32'h0,  32'hC,  32'hD,  5'b00110, 32'h0,  32'h0,  32'hC};
    tbl[22] = '{7'b0100110, 32'h0,  32'h0,  32'h0,  5'b00010, 32'h0,  32'h0,  32'hD};
    tbl[23] = '{7'b0100010, 32'h0,  32'hE,  32'h0,  5'b00000, 32'h0,  32'h0,  32'h0};
    tbl[24] = '{7'b0100010, 32'h0,  32'hE,  32'h0,  5'b00000, 32'h0,  32'h0,  32'h0};
    tbl[25] = '{7'b0100100, 32'h0,  32'hE,  32'hF,  5'b00000, 32'h0,  32'h0,  32'h0};
    tbl[26] = '{7'b0100001, 32'h0,  32'hE,  32'hF,  5'b00000, 32'h0,  32'h0,  32'h0};
    tbl[27] = '{7'b0100000, 32'h0,  32'hE,  32'hF,  5'b00110, 32'h0,  32'h0,  32'hE};
    tbl[28] = '{7'b0100001, 32'h0,  32'h11, 32'h12, 5'b00000, 32'h0,  32'h0,  32'h0};
    tbl[29] = '{7'b0100000, 32'h0,  32'h11, 32'h12, 5'b00010, 32'h0,  32'h0,  32'hF};
    tbl[30] = '{7'b0000000, 32'h90, 32'h11, 32'h12, 5'b10110, 32'h0,  32'h0,  32'h11};
    tbl[31] = '{7'b0000110, 32'hA0, 32'h0,  32'h0,  5'b11010, 32'h90, 32'hA0, 32'h12};
    tbl[32] = '{7'b0100110, 32'h0,  32'h0,  32'h0,  5'b00001, 32'h0,  32'h0,  32'h0};
    tbl[33] = '{7'b0100110, 32'h0,  32'h0,  32'h0,  5'b00000, 32'h0,  32'h0,  32'h0};
    for (int r = 0; r < 34; r++) begin
      @(negedge clock);
      reset = tbl[r].fi[6]; iq_in_empty = tbl[r].fi[5];
      xreal_out_full = tbl[r].fi[4]; ximag_out_full = tbl[r].fi[3];
      yreal_in_empty = tbl[r].fi[2]; yimag_in_empty = tbl[r].fi[1]; iq_out_full = tbl[r].fi[0];
      iq_in_dout = tbl[r].din; yreal_in_dout = tbl[r].yr; yimag_in_dout = tbl[r].yi;
      #1;
      chk1($sformatf("row%0d_in_rd", r), iq_in_rd_en, tbl[r].fe[4]);
      chk1($sformatf("row%0d_xr_wr", r), xreal_out_wr_en, tbl[r].fe[3]);
      chk1($sformatf("row%0d_xi_wr", r), ximag_out_wr_en, tbl[r].fe[3]);
      chk32($sformatf("row%0d_xr_din", r), xreal_out_din, tbl[r].xr);
      chk32($sformatf("row%0d_xi_din", r), ximag_out_din, tbl[r].xi);
      chk1($sformatf("row%0d_yr_rd", r), yreal_in_rd_en, tbl[r].fe[2]);
      chk1($sformatf("row%0d_yi_rd", r), yimag_in_rd_en, tbl[r].fe[2]);
      chk1($sformatf("row%0d_out_wr", r), iq_out_wr_en, tbl[r].fe[1]);
      chk32($sformatf("row%0d_out_din", r), iq_out_din, tbl[r].od);
      chk1($sformatf("row%0d_frame_done", r), frame_done, tbl[r].fe[0]);
    end
    chk16("table_frame_count", frame_count, 16'd1);

    do_reset();
    for (int p = 0; p < 9; p++) push_res(32'h100 + 32'(2 * p), 32'h101 + 32'(2 * p));
    fd_seen = 0;
    drain(1'b0, 100);
    chk16("frames_after_9_pairs", frame_count, 16'd2);
    chk32("pulses_after_9_pairs", 32'(fd_seen), 32'd2);
    for (int p = 0; p < 3; p++) push_res(32'h200 + 32'(2 * p), 32'h201 + 32'(2 * p));
    drain(1'b0, 100);
    chk16("frames_after_12_pairs", frame_count, 16'd3);
    chk32("pulses_after_12_pairs", 32'(fd_seen), 32'd3);

    push_res(32'h77, 32'h88);
    inq.push_back(32'h31);
    cyc(1'b0);
    do_reset();
    push_in(32'h41, 32'h42);
    push_res(32'h99, 32'hAA);
    drain(1'b0, 50);
    chk16("frame_count_after_midpair_reset", frame_count, 16'd0);

    do_reset();
    for (int p = 0; p < 60; p++) begin
      push_in($urandom, $urandom);
      push_res($urandom, $urandom);
    end
    fd_seen = 0;
    drain(1'b1, 3000);
    chk16("random_frame_count", frame_count, 16'd15);
    chk32("random_pulses", 32'(fd_seen), 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
